// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction-fetch stage between the PC register and decode.
// Issues W_pc to instruction memory over a split request/response handshake,
// tags each accepted request with its PC, queues returned words in a small
// FIFO and hands them to decode with valid/ready. A redirect flush drops
// everything queued and marks in-flight responses for discard.
// Optional build macro FETCH_ADDR_ERR_EN: a misaligned W_pc is not fetched;
// once live requests drain, an address-error entry (D_adel=1) is queued.
module if_fetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] W_pc,
  output logic        W_pc_en,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        D_valid,
  input  logic        D_ready,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst
`ifdef FETCH_ADDR_ERR_EN
  ,
  output logic        D_adel
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  // Discarded responses can pile up across back-to-back flushes, so the
  // discard counter is wider than the outstanding counter.
  localparam int DW = 8;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S  = SW'(DEPTH);
  localparam logic [1:0]    MAXO_C   = 2'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

  // Data storage: never reset, only read through the count-qualified head.
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] tag_mem  [MAX_OUTSTANDING];

  // Control state.
  logic          boot_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    out_q, out_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d;

  logic          can_issue;
  logic          adel_push;
  logic          accept;
  logic          resp_live;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic [SW-1:0] occupancy;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;

`ifdef FETCH_ADDR_ERR_EN
  logic          adel_mem [DEPTH];
  logic          err_q, err_d;
`endif

  // Tag queue depth need not be a power of two, so wrap explicitly.
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TAG_LAST) ? '0 : p + 1'b1;
  endfunction

  // Queued words plus live in-flight requests; discarded ones reserve nothing.
  assign occupancy = SW'(cnt_q) + SW'(out_q);

  // Issue decision and the optional address-error entry.
  always_comb begin
    can_issue = ~boot_q & ~flush & (out_q < MAXO_C) & (occupancy < DEPTH_S);
    adel_push = 1'b0;
`ifdef FETCH_ADDR_ERR_EN
    can_issue = can_issue & (W_pc[1:0] == 2'b00) & ~err_q;
    adel_push = ~boot_q & ~flush & ~err_q & (W_pc[1:0] != 2'b00) &
                (out_q == 2'd0) & (cnt_q < DEPTH_C);
`endif
  end

  assign inst_req  = can_issue;
  assign inst_addr = W_pc;
  assign accept    = can_issue & inst_addr_ok;
  // The boot step releases the reset PC; rst gating keeps W_pc_en low in reset.
  assign W_pc_en   = (boot_q & ~rst) | accept | adel_push;

  assign resp_live = inst_data_ok & (disc_q == '0);
  assign resp_drop = inst_data_ok & (disc_q != '0);
  assign push      = (resp_live & ~flush) | adel_push;
  assign pop       = D_valid & D_ready & ~flush;
  assign push_pc   = adel_push ? W_pc : tag_mem[tag_rd_q];
  assign push_inst = adel_push ? 32'h0000_0000 : inst_rdata;

  assign D_valid = (cnt_q != '0);
  assign D_pc    = D_valid ? pc_mem[rd_ptr_q]   : 32'h0000_0000;
  assign D_inst  = D_valid ? inst_mem[rd_ptr_q] : 32'h0000_0000;
`ifdef FETCH_ADDR_ERR_EN
  assign D_adel  = D_valid & adel_mem[rd_ptr_q];
`endif

  // Next-state for FIFO pointers/count, outstanding/discard counts, tag queue.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    disc_d   = disc_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      out_d    = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
      // Every live request becomes a discard, except a response landing in
      // this very cycle, which is dropped here and never counted.
      disc_d   = disc_q + DW'(out_q) - DW'(inst_data_ok);
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      out_d = out_q + 2'(accept) - 2'(resp_live);
      if (resp_drop) disc_d = disc_q - 1'b1;
      // Discarded requests lost their tags at flush, so only live ones pop.
      if (accept)    tag_wr_d = tag_inc(tag_wr_q);
      if (resp_live) tag_rd_d = tag_inc(tag_rd_q);
    end
  end

`ifdef FETCH_ADDR_ERR_EN
  // The error entry is emitted once and blocks further issue until redirect.
  always_comb begin
    err_d = err_q | adel_push;
    if (flush) err_d = 1'b0;
  end
`endif

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_q   <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      disc_q   <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
`ifdef FETCH_ADDR_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      boot_q   <= 1'b0;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
`ifdef FETCH_ADDR_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  // FIFO entry and PC tag storage writes.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      inst_mem[wr_ptr_q] <= push_inst;
`ifdef FETCH_ADDR_ERR_EN
      adel_mem[wr_ptr_q] <= adel_push;
`endif
    end
    if (accept) tag_mem[tag_wr_q] <= W_pc;
  end

  // The issue rule guarantees FIFO room and a matching request per response.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt_q == DEPTH_C)));
  a_resp_has_req: assert property (@(posedge clk) disable iff (rst)
    !(resp_live && (out_q == 2'd0)));

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: environment PC register, in-order memory with
// random latency, and a queue-level reference of what decode must see.
module tb_if_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] W_pc;
  logic        W_pc_en;
  logic        flush;
  logic [31:0] flush_tgt;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        D_valid;
  logic        D_ready;
  logic [31:0] D_pc;
  logic [31:0] D_inst;
`ifdef FETCH_ADDR_ERR_EN
  logic        D_adel;
`endif

  always #5 clk = ~clk;

  if_fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .W_pc(W_pc), .W_pc_en(W_pc_en), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .D_valid(D_valid), .D_ready(D_ready), .D_pc(D_pc), .D_inst(D_inst)
`ifdef FETCH_ADDR_ERR_EN
    , .D_adel(D_adel)
`endif
  );

  // Environment PC register: reset value must never be fetched.
  logic [31:0] pc_q;
  always @(posedge clk or posedge rst) begin
    if (rst)          pc_q <= 32'hFFFF_FFFC;
    else if (flush)   pc_q <= flush_tgt;
    else if (W_pc_en) pc_q <= pc_q + 32'd4;
  end
  assign W_pc = pc_q;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    int          ep;
  } req_t;

  req_t        mem_q[$];   // requests the memory still owes, in order
  logic [31:0] fifo_m[$];  // PCs decode should see, in order
  int          cyc, epoch, checks, errors;
  logic [31:0] exp_next;
  bit          exp_req_m;
  int          k_aok, k_rdy, k_dok, k_flush, lat_lo, lat_hi;
  bit          force_flush;
  logic [31:0] force_tgt;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a * 32'h0000_9E37) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic int live_out();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].ep == epoch) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    inst_addr_ok = (int'($urandom_range(0, 99)) < k_aok);
    D_ready      = (int'($urandom_range(0, 99)) < k_rdy);
    if (force_flush) begin
      flush     = 1'b1;
      flush_tgt = force_tgt;
    end else begin
      flush     = (int'($urandom_range(0, 99)) < k_flush);
      flush_tgt = $urandom & 32'h0000_FFFC;
    end
    inst_data_ok = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc) &&
                   (int'($urandom_range(0, 99)) < k_dok);
    inst_rdata   = inst_data_ok ? rdata_of(mem_q[0].addr) : $urandom;
  endtask

  task automatic settle_and_check();
    int live;
    live      = live_out();
    exp_req_m = !flush && (live < MAXO) && (fifo_m.size() + live < DEPTH);
    chk("inst_req", inst_req, exp_req_m);
    chk("w_pc_en", W_pc_en, exp_req_m & inst_addr_ok);
    if (exp_req_m) chk("inst_addr", inst_addr, exp_next);
    chk("d_valid", D_valid, fifo_m.size() > 0);
    if (fifo_m.size() > 0) begin
      chk("d_pc", D_pc, fifo_m[0]);
      chk("d_inst", D_inst, rdata_of(fifo_m[0]));
    end
  endtask

  task automatic finish_cycle();
    req_t r;
    if (fifo_m.size() > 0 && D_ready && !flush) void'(fifo_m.pop_front());
    if (inst_data_ok) begin
      r = mem_q.pop_front();
      if (r.ep == epoch && !flush) fifo_m.push_back(r.addr);
    end
    if (exp_req_m && inst_addr_ok) begin
      r.addr = exp_next;
      r.rdy  = cyc + int'($urandom_range(lat_lo, lat_hi));
      r.ep   = epoch;
      mem_q.push_back(r);
      exp_next = exp_next + 32'd4;
    end
    if (flush) begin
      fifo_m.delete();
      epoch++;
      exp_next = flush_tgt;
    end
    force_flush = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    drive();
    #1;
    settle_and_check();
    finish_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0; flush_tgt = '0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = '0; D_ready = 1'b0;
    mem_q.delete();
    fifo_m.delete();
    epoch++;
    exp_next = 32'h0000_0000;
    @(posedge clk);
    #1;
    chk("rst_inst_req", inst_req, 1'b0);
    chk("rst_w_pc_en", W_pc_en, 1'b0);
    chk("rst_d_valid", D_valid, 1'b0);
    chk("rst_d_pc", D_pc, 32'h0);
    chk("rst_d_inst", D_inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    // Boot cycle: PC advances off the reset value, nothing is fetched.
    drive();
    flush = 1'b0;
    #1;
    chk("boot_w_pc_en", W_pc_en, 1'b1);
    chk("boot_inst_req", inst_req, 1'b0);
    chk("boot_d_valid", D_valid, 1'b0);
    exp_req_m = 1'b0;
    finish_cycle();
  endtask

  task automatic knobs(input int aok, input int rdy, input int dok,
                       input int llo, input int lhi, input int fl);
    k_aok = aok; k_rdy = rdy; k_dok = dok;
    lat_lo = llo; lat_hi = lhi; k_flush = fl;
  endtask

  initial begin
    bit found;
    checks = 0; errors = 0; cyc = 0; epoch = 0;
    force_flush = 1'b0; force_tgt = '0; exp_req_m = 1'b0;
    knobs(100, 100, 100, 1, 1, 0);
    do_reset();

    // Streaming fetch from 0 with an always-ready memory and decoder.
    run(12);

    // Decoder stalls: exactly DEPTH fetches land, then issue and PC freeze.
    knobs(100, 0, 100, 1, 1, 0);
    run(12);
    drive(); #1; settle_and_check();
    chk("bp_inst_req", inst_req, 1'b0);
    chk("bp_w_pc_en", W_pc_en, 1'b0);
    chk("bp_d_valid", D_valid, 1'b1);
    finish_cycle();
    knobs(100, 100, 100, 1, 1, 0);
    run(20);

    // Refill then simultaneous push/pop across pointer wrap.
    for (int rep = 0; rep < 3; rep++) begin
      knobs(100, 0, 100, 1, 1, 0);
      run(8);
      knobs(100, 100, 100, 1, 1, 0);
      run(20);
    end

    // Memory refuses the address: request held with a stable address.
    knobs(0, 100, 100, 1, 1, 0);
    run(6);
    for (int i = 0; i < 5; i++) begin
      drive(); #1; settle_and_check();
      chk("stall_inst_req", inst_req, 1'b1);
      chk("stall_w_pc_en", W_pc_en, 1'b0);
      chk("stall_addr", inst_addr, exp_next);
      finish_cycle();
    end

    // Two slow requests in flight at 0x100/0x104, then redirect to 0x200.
    knobs(100, 100, 100, 1, 1, 0);
    force_flush = 1'b1; force_tgt = 32'h0000_0100;
    step();
    knobs(100, 100, 100, 8, 8, 0);
    step();
    step();
    chk("two_live", live_out(), 2);
    force_flush = 1'b1; force_tgt = 32'h0000_0200;
    step();
    knobs(100, 100, 100, 1, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive(); #1; settle_and_check();
      if (D_valid === 1'b1) begin
        found = 1'b1;
        chk("flush_first_pc", D_pc, 32'h0000_0200);
      end
      finish_cycle();
    end
    chk("flush_timeout", found, 1'b1);

    // Randomized traffic with flushes.
    for (int blk = 0; blk < 12; blk++) begin
      knobs(int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
            int'($urandom_range(40, 100)), 1, int'($urandom_range(1, 6)),
            int'($urandom_range(0, 5)));
      run(50);
    end

    // Reset in the middle of traffic, then stream again.
    knobs(100, 100, 100, 1, 3, 0);
    run(5);
    do_reset();
    run(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
